// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide unit
package muldiv_pkg;
    localparam int XLEN = 32;
    localparam int ITER = 32;
    localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFFFFFF;
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_t;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;
endpackage

// File: rtl/adder_nb.sv
// adder_nb: N-bit adder; cin=1 turns it into x - y
// ports: x, y operands; cin subtract select; sum result (carry/borrow in sum[N-1] when operands are zero-extended)
module adder_nb #(
    parameter int N = 33
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic [N-1:0] sum
);
    assign sum = x + (cin ? ~y : y) + {{(N-1){1'b0}}, cin};
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide with start/busy/done handshake
// ports: clk, rst (async, active-high); start, op (funct3), a, b request;
//        busy (CALC/FIX), done (one-cycle pulse), rslt (held until next result loads)
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] rslt
);
    state_t          state;
    op_t             op_q;
    logic [XLEN-1:0] md, hi, lo;
    logic            neg;
    logic [4:0]      cnt;

    logic            accept, a_neg, b_neg, div_zero, div_ovf, is_div;
    logic [XLEN-1:0] a_mag, b_mag, special_q, qr, qr_f, fix_val;
    logic [XLEN:0]   add_x, add_y, sum, mul_next;
    logic [2*XLEN-1:0] prod, prod_f;

    assign busy   = (state == S_CALC) || (state == S_FIX);
    assign done   = (state == S_DONE);
    assign accept = start && (state == S_IDLE || state == S_DONE);

    assign a_neg = a[31] && (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
    assign b_neg = b[31] && (op == OP_MULH || op == OP_DIV || op == OP_REM);
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    assign div_zero  = op[2] && (b == '0);
    assign div_ovf   = op[2] && !op[0] && (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    assign special_q = div_zero ? (op[1] ? a : DIV_ZERO_Q) : (op[1] ? 32'h0 : 32'h80000000);

    // Divide feeds the left-shifted remainder; multiply feeds the high accumulator word.
    assign is_div = op_q[2];
    assign add_x  = is_div ? {hi, lo[31]} : {1'b0, hi};
    assign add_y  = {1'b0, md};

    adder_nb #(.N(XLEN + 1)) u_add (
        .x   (add_x),
        .y   (add_y),
        .cin (is_div),
        .sum (sum)
    );

    assign mul_next = lo[0] ? sum : {1'b0, hi};

    assign prod    = {hi, lo};
    assign prod_f  = neg ? -prod : prod;
    assign qr      = op_q[1] ? hi : lo;
    assign qr_f    = neg ? -qr : qr;
    assign fix_val = is_div ? qr_f : (op_q == OP_MUL ? prod_f[31:0] : prod_f[63:32]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            op_q  <= OP_MUL;
            md    <= '0;
            hi    <= '0;
            lo    <= '0;
            neg   <= 1'b0;
            cnt   <= '0;
            rslt  <= '0;
        end else if (accept) begin
            if (div_zero || div_ovf) begin
                rslt  <= special_q;
                state <= S_DONE;
            end else begin
                op_q  <= op_t'(op);
                md    <= op[2] ? b_mag : a_mag;
                lo    <= op[2] ? a_mag : b_mag;
                hi    <= '0;
                neg   <= (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
                cnt   <= '0;
                state <= S_CALC;
            end
        end else if (state == S_DONE) begin
            state <= S_IDLE;
        end else if (state == S_CALC) begin
            // Divide: sum[32] set means the trial subtraction went negative, so restore.
            if (is_div) begin
                hi <= sum[32] ? add_x[31:0] : sum[31:0];
                lo <= {lo[30:0], ~sum[32]};
            end else begin
                {hi, lo} <= {mul_next, lo[31:1]};
            end
            cnt <= cnt + 5'd1;
            if (cnt == 5'(ITER - 1))
                state <= S_FIX;
        end else if (state == S_FIX) begin
            rslt  <= fix_val;
            state <= S_DONE;
        end
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multi-cycle multiply/divide unit implementing the RV32M operations. It sits beside the single-cycle ALU in the execute stage and takes the same 32-bit operand pair. It returns a 32-bit result under a start/busy/done handshake that the hazard unit uses to stall the pipeline. Multiply uses radix-2 shift-add; divide uses radix-2 restoring division. Both share one 33-bit add/subtract datapath.

## Interface
- XLEN, 32: operand/result width; only 32 is supported.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  32  rs1 operand (multiplicand/dividend); captured on accepted start.
- b  in  32  rs2 operand (multiplier/divisor); captured on accepted start.
- busy  out  1  high in CALC and FIX.
- done  out  1  one-cycle pulse; high exactly in DONE.
- rslt  out  32  result; valid from done and held until the next accepted start's result is loaded.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE + start: latch op and operand magnitudes.
  - Negate a when op is signed (MULH, MULHSU, DIV, REM) and a[31]=1.
  - Negate b when op is MULH, DIV or REM and b[31]=1.
  - Latch result sign:
    - MUL*: a_neg XOR b_neg.
    - DIV: a_neg XOR b_neg.
    - REM: a_neg.
  - Clear the 5-bit iteration counter. Go to CALC.
- IDLE/DONE without start: DONE goes to IDLE; IDLE stays.
- Divide special cases bypass CALC/FIX. They go from IDLE/DONE directly to DONE with rslt loaded:
  - b=0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give a.
  - DIV/REM with a=0x80000000 and b=0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- CALC: one iteration per cycle, 32 iterations. After the counter reaches 31, go to FIX.
  - Multiply: 64-bit {hi,lo} accumulator. If lo[0], add the multiplicand to hi with 33-bit carry. Shift right 1.
  - Divide: shift {rem,quot} left 1. Compute trial rem − divisor (33-bit). If non-negative, keep it and set quot[0].
- FIX: apply two's-complement negation if the sign flag is set: 64-bit negation for MUL*, 32-bit for quotient/remainder.
  - Select the result: MUL takes the low word; MULH, MULHSU and MULHU take the high word; DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Load rslt and go to DONE.
- start during CALC/FIX is ignored; no queuing.
- op/a/b changes after acceptance have no effect.

## Timing
- Reset values: state IDLE, busy 0, done 0, rslt 0x00000000, counter 0, internal registers 0.
- Normal op, start high in cycle N (IDLE or DONE):
  - CALC in cycles N+1..N+32, FIX in N+33, done=1 in N+34.
  - busy=1 in N+1..N+33.
- Special case: done=1 in cycle N+1; busy stays 0.
- Back-to-back: start in the DONE cycle is accepted. done drops next cycle; the previous rslt holds until the new one loads.
- Reset during any state: immediate return to reset values. No partial result appears and no done pulse follows.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- muldiv_pkg holds:
  - the typedef enum for op (the funct3 encodings above);
  - the typedef enum for state;
  - localparams XLEN=32 and ITER=32;
  - the DIV_ZERO_Q constant 32'hFFFFFFFF.
- Sub-module: adder_nb #(33) instantiated once for the shared add/trial-subtract step, with cin selecting subtraction.
  - Everything else stays in muldiv_unit: FSM, counter, operand/accumulator registers, sign fix-up.

## Test plan
- MUL a=7, b=0xFFFFFFFD -> rslt 0xFFFFFFEB, done at N+34, busy high N+1..N+33.
- a=b=0xFFFFFFFF: MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF; MUL -> 0x00000001.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both with done at N+1.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Start pulsed at N+5 during CALC -> ignored; original result at N+34.
  - rst at N+10 -> busy/done/rslt 0 immediately, no done pulse; a subsequent MULHU 3×5 -> 0.
- Start held in the DONE cycle with a new DIVU 9/3 -> accepted; done at +34; rslt holds the old value until it changes to 3.
